dmem_responder: RTL and testbench

Memory-side responder for the data cache's miss/write-through traffic. Takes single-word read and write requests over a valid/ready handshake, applies a fixed access latency, and returns one response per request over a second valid/ready channel. It replaces direct array indexing from the MEM stage and models main data memory behind the cache.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, defaults and helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH_DEFAULT = 256;
    localparam int unsigned DMEM_LAT_DEFAULT   = 3;
    localparam int unsigned DMEM_CNT_W_DEFAULT = 16;
    localparam int unsigned DMEM_DATA_W        = 32;
    localparam int unsigned DMEM_ADDR_W        = 32;
    localparam int unsigned DMEM_LAT_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Request payload captured at acceptance
    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

    // Misaligned or beyond the last word of a depth-word array
    function automatic logic addr_err(input logic [DMEM_ADDR_W-1:0] addr,
                                      input int unsigned             depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= DMEM_ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide backing store: synchronous write, combinational read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_addr,
    input  logic [DMEM_DATA_W-1:0]     i_wdata,
    output logic [DMEM_DATA_W-1:0]     o_rdata_c
);

    logic [DMEM_DATA_W-1:0] r_mem [DEPTH];

    // Storage write; contents survive reset by design
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder with fixed access latency and
// saturating read/write statistics.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int unsigned LATENCY = DMEM_LAT_DEFAULT,
    parameter int unsigned CNT_W   = DMEM_CNT_W_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [DMEM_ADDR_W-1:0] req_addr,
    input  logic [DMEM_DATA_W-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DMEM_DATA_W-1:0] rsp_rdata,
    output logic                   rsp_we,
    output logic                   rsp_err,
    output logic [CNT_W-1:0]       rd_count,
    output logic [CNT_W-1:0]       wr_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmem_state_t            r_state,      w_state_nxt;
    logic [DMEM_LAT_W-1:0]  r_lat_cnt,    w_lat_cnt_nxt;
    dmem_req_t              r_req,        w_req_nxt;
    logic                   r_req_ready,  w_req_ready_nxt;
    logic                   r_rsp_valid,  w_rsp_valid_nxt;
    logic [DMEM_DATA_W-1:0] r_rsp_rdata,  w_rsp_rdata_nxt;
    logic                   r_rsp_we,     w_rsp_we_nxt;
    logic                   r_rsp_err,    w_rsp_err_nxt;
    logic [CNT_W-1:0]       r_rd_count,   w_rd_count_nxt;
    logic [CNT_W-1:0]       r_wr_count,   w_wr_count_nxt;

    logic                   w_err;
    logic                   w_access;
    logic                   w_arr_we;
    logic [AW-1:0]          w_arr_addr;
    logic [DMEM_DATA_W-1:0] w_arr_rdata;

    // The access fires on the last latency cycle, i.e. at the edge entering RESP
    assign w_err      = addr_err(r_req.addr, DEPTH);
    assign w_access   = (r_state == WAIT) && (r_lat_cnt == '0);
    assign w_arr_we   = w_access && r_req.we && !w_err;
    assign w_arr_addr = r_req.addr[AW+1:2];

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clock     (clock),
        .i_we      (w_arr_we),
        .i_addr    (w_arr_addr),
        .i_wdata   (r_req.wdata),
        .o_rdata_c (w_arr_rdata)
    );

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lat_cnt   <= '0;
            r_req       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_we    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_req       <= w_req_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_we    <= w_rsp_we_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rd_count  <= w_rd_count_nxt;
            r_wr_count  <= w_wr_count_nxt;
        end
    end

    // Next-state, latency countdown, response formation and statistics
    always_comb begin
        w_state_nxt     = r_state;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_req_nxt       = r_req;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_we_nxt    = r_rsp_we;
        w_rsp_err_nxt   = r_rsp_err;
        w_rd_count_nxt  = r_rd_count;
        w_wr_count_nxt  = r_wr_count;

        case (r_state)
            IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_req_nxt.we    = req_we;
                    w_req_nxt.addr  = req_addr;
                    w_req_nxt.wdata = req_wdata;
                    // LATENCY=1 spends its one cycle here with the count already at zero
                    w_lat_cnt_nxt   = DMEM_LAT_W'(LATENCY - 1);
                    w_req_ready_nxt = 1'b0;
                    w_state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_we_nxt    = r_req.we;
                    w_rsp_err_nxt   = w_err;
                    w_rsp_rdata_nxt = (r_req.we || w_err) ? '0 : w_arr_rdata;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - DMEM_LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_we_nxt    = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    if (!r_rsp_err) begin
                        if (r_rsp_we) begin
                            if (r_wr_count != '1) begin
                                w_wr_count_nxt = r_wr_count + CNT_W'(1);
                            end
                        end else begin
                            if (r_rd_count != '1) begin
                                w_rd_count_nxt = r_rd_count + CNT_W'(1);
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_req_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_we    = r_rsp_we;
    assign rsp_err   = r_rsp_err;
    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: default instance (LATENCY=3, CNT_W=16) and a
// LATENCY=1 / CNT_W=4 instance for throughput and saturation.
module tb_dmem_responder;

    localparam int unsigned LAT0 = 3;

    logic        clock;
    logic        reset;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] rd_count, wr_count;

    logic        req_valid1, req_ready1, req_we1;
    logic [31:0] req_addr1, req_wdata1;
    logic        rsp_valid1, rsp_ready1, rsp_we1, rsp_err1;
    logic [31:0] rsp_rdata1;
    logic [3:0]  rd_count1, wr_count1;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(
        .DEPTH   (256),
        .LATENCY (LAT0),
        .CNT_W   (16)
    ) u_dut0 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_we    (rsp_we),
        .rsp_err   (rsp_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    dmem_responder #(
        .DEPTH   (256),
        .LATENCY (1),
        .CNT_W   (4)
    ) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_we    (req_we1),
        .req_addr  (req_addr1),
        .req_wdata (req_wdata1),
        .rsp_valid (rsp_valid1),
        .rsp_ready (rsp_ready1),
        .rsp_rdata (rsp_rdata1),
        .rsp_we    (rsp_we1),
        .rsp_err   (rsp_err1),
        .rd_count  (rd_count1),
        .wr_count  (wr_count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on the default instance; called one step after an edge while idle
    task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(LAT0));
        check("rsp_we", 32'(rsp_we), 32'(we));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, exp_rdata);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        check("hs_req_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc;
        int last_idle;
        int n_rsp;

        reset      = 1'b1;
        req_valid  = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0; rsp_ready  = 1'b0;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; rsp_ready1 = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_we", 32'(rsp_we), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Write then read back
        txn0(1'b1, 32'h10, 32'h1234_5678, 0, 32'h0, 1'b0);
        txn0(1'b0, 32'h10, 32'h0, 0, 32'h1234_5678, 1'b0);
        check("wr_rd_rd_count", 32'(rd_count), 32'd1);
        check("wr_rd_wr_count", 32'(wr_count), 32'd1);

        // Backpressure for five cycles
        txn0(1'b0, 32'h10, 32'h0, 5, 32'h1234_5678, 1'b0);
        check("bp_rd_count", 32'(rd_count), 32'd2);

        // Errors leave the array and counters alone
        txn0(1'b1, 32'h0, 32'hA5A5_A5A5, 0, 32'h0, 1'b0);
        txn0(1'b0, 32'h2, 32'h0, 0, 32'h0, 1'b1);
        txn0(1'b0, 32'h400, 32'h0, 0, 32'h0, 1'b1);
        txn0(1'b1, 32'h400, 32'hFFFF_FFFF, 0, 32'h0, 1'b1);
        check("err_rd_count", 32'(rd_count), 32'd2);
        check("err_wr_count", 32'(wr_count), 32'd2);
        txn0(1'b0, 32'h0, 32'h0, 0, 32'hA5A5_A5A5, 1'b0);

        // Last legal word
        txn0(1'b1, 32'h3FC, 32'h7E57_0001, 0, 32'h0, 1'b0);
        txn0(1'b0, 32'h3FC, 32'h0, 0, 32'h7E57_0001, 1'b0);
        check("edge_rd_count", 32'(rd_count), 32'd4);
        check("edge_wr_count", 32'(wr_count), 32'd3);

        // Reset in the middle of a write's latency window
        txn0(1'b1, 32'h20, 32'hCAFE_F00D, 0, 32'h0, 1'b0);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        check("mid_rst_rsp_we", 32'(rsp_we), 32'd0);
        check("mid_rst_wr_count", 32'(wr_count), 32'd0);
        check("mid_rst_rd_count", 32'(rd_count), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        txn0(1'b0, 32'h20, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
        check("after_rst_rd_count", 32'(rd_count), 32'd1);
        check("after_rst_wr_count", 32'(wr_count), 32'd0);

        // LATENCY=1 instance: seed word 0
        req_we1 = 1'b1; req_addr1 = 32'h0; req_wdata1 = 32'h0BAD_F00D; req_valid1 = 1'b1;
        rsp_ready1 = 1'b1;
        @(posedge clock); #1;
        req_valid1 = 1'b0;
        check("l1_wait_valid", 32'(rsp_valid1), 32'd0);
        @(posedge clock); #1;
        check("l1_wr_valid", 32'(rsp_valid1), 32'd1);
        check("l1_wr_we", 32'(rsp_we1), 32'd1);
        @(posedge clock); #1;
        check("l1_wr_idle", 32'(req_ready1), 32'd1);
        check("l1_wr_count", 32'(wr_count1), 32'd1);

        // Back-to-back reads with rsp_ready tied high
        req_we1 = 1'b0; req_addr1 = 32'h0; req_valid1 = 1'b1;
        cyc = 0; last_idle = -1; n_rsp = 0;
        while (n_rsp < 20 && cyc < 200) begin
            if (req_ready1) begin
                if (last_idle >= 0) check("l1_period", 32'(cyc - last_idle), 32'd3);
                last_idle = cyc;
            end
            if (rsp_valid1) begin
                check("l1_rsp_lat", 32'(cyc - last_idle), 32'd2);
                check("l1_rdata", rsp_rdata1, 32'h0BAD_F00D);
                n_rsp++;
                if (n_rsp == 20) req_valid1 = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
        end
        check("l1_rsp_total", 32'(n_rsp), 32'd20);
        check("l1_rd_sat", 32'(rd_count1), 32'd15);
        check("l1_wr_hold", 32'(wr_count1), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        check("l1_idle_after", 32'(rsp_valid1), 32'd0);
        check("l1_rd_sat_hold", 32'(rd_count1), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
